// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM arbiter: RAM geometry, the lock timeout
// and the FSM / port enumerations used by mem_arbiter and rr_arb2.
package mem_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DATA_W     = 16;
    // Consecutive locked cycles (including the locking grant) before the
    // owner is forced off the RAM.
    localparam int unsigned LOCK_MAX   = 16;
    localparam int unsigned LOCK_CNT_W = $clog2(LOCK_MAX);

    typedef enum logic [1:0] {
        ARB,
        LOCK_CPU,
        LOCK_AUX
    } arb_state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_AUX
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick. Purely combinational; the caller stores the
// previous winner.
//   req_cpu_i, req_aux_i : requests
//   last_win_i           : port granted most recently
//   gnt_cpu_o, gnt_aux_o : one-hot (or zero) grant
module rr_arb2
    import mem_pkg::*;
(
    input  logic  req_cpu_i,
    input  logic  req_aux_i,
    input  port_t last_win_i,
    output logic  gnt_cpu_o,
    output logic  gnt_aux_o
);

    always_comb begin
        gnt_cpu_o = 1'b0;
        gnt_aux_o = 1'b0;
        if (req_cpu_i && req_aux_i) begin
            // Tie: the port that did not win last time goes first.
            if (last_win_i == PORT_AUX) begin
                gnt_cpu_o = 1'b1;
            end else begin
                gnt_aux_o = 1'b1;
            end
        end else begin
            gnt_cpu_o = req_cpu_i;
            gnt_aux_o = req_aux_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port 1K x 16 data RAM between the CPU load/store port and
// the auxiliary port. Round-robin arbitration, lock for atomic sequences with a
// starvation timeout, and routing of 1-cycle-latency read data to the reader.
//   clk, reset           : clock, synchronous active-high reset
//   cpu_* / aux_*        : req, we, lock, addr, wdata in; gnt, rvalid, rdata out
//   ram_we/addr/din      : RAM command (from the granted port)
//   ram_dout             : RAM read data, valid the cycle after the address
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic              aux_lock,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t            state_q, state_d;
    port_t                 last_win_q, last_win_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  tag_valid_q, tag_valid_d;
    port_t                 tag_port_q, tag_port_d;
    logic [DATA_W-1:0]     cpu_rdata_q, aux_rdata_q;

    logic  rr_cpu, rr_aux;
    logic  granted, gnt_we, gnt_lock;
    port_t gnt_port, owner;

    rr_arb2 u_rr_arb2 (
        .req_cpu_i  (cpu_req),
        .req_aux_i  (aux_req),
        .last_win_i (last_win_q),
        .gnt_cpu_o  (rr_cpu),
        .gnt_aux_o  (rr_aux)
    );

    // Grants: round-robin in ARB, owner only while locked, nothing in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    cpu_gnt = rr_cpu;
                    aux_gnt = rr_aux;
                end
                LOCK_CPU: cpu_gnt = cpu_req;
                LOCK_AUX: aux_gnt = aux_req;
                default:  ;
            endcase
        end
    end

    assign granted  = cpu_gnt | aux_gnt;
    assign gnt_port = aux_gnt ? PORT_AUX : PORT_CPU;
    assign gnt_we   = aux_gnt ? aux_we   : cpu_we;
    assign gnt_lock = aux_gnt ? aux_lock : cpu_lock;
    assign owner    = (state_q == LOCK_AUX) ? PORT_AUX : PORT_CPU;

    // RAM mux; address defaults to the CPU side when idle.
    assign ram_we   = granted & gnt_we;
    assign ram_addr = aux_gnt ? aux_addr  : cpu_addr;
    assign ram_din  = aux_gnt ? aux_wdata : cpu_wdata;

    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        lock_cnt_d = lock_cnt_q;
        if (granted) begin
            last_win_d = gnt_port;
        end
        case (state_q)
            ARB: begin
                if (granted && gnt_lock) begin
                    state_d    = (gnt_port == PORT_CPU) ? LOCK_CPU : LOCK_AUX;
                    // The locking grant itself is the first locked cycle.
                    lock_cnt_d = LOCK_CNT_W'(1);
                end
            end
            LOCK_CPU, LOCK_AUX: begin
                if ((granted && !gnt_lock) || lock_cnt_q == LOCK_CNT_W'(LOCK_MAX - 1)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    // On timeout the owner counts as last winner so the other
                    // port takes the next tie.
                    last_win_d = owner;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign tag_valid_d = granted & ~gnt_we;
    assign tag_port_d  = gnt_port;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            last_win_q  <= PORT_AUX;
            lock_cnt_q  <= '0;
            tag_valid_q <= 1'b0;
            tag_port_q  <= PORT_CPU;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_win_q  <= last_win_d;
            lock_cnt_q  <= lock_cnt_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_dout;
            end
            if (aux_rvalid) begin
                aux_rdata_q <= ram_dout;
            end
        end
    end

    // Reset suppresses a return that was already in flight.
    assign cpu_rvalid = tag_valid_q && (tag_port_q == PORT_CPU) && !reset;
    assign aux_rvalid = tag_valid_q && (tag_port_q == PORT_AUX) && !reset;
    assign cpu_rdata  = cpu_rvalid ? ram_dout : cpu_rdata_q;
    assign aux_rdata  = aux_rvalid ? ram_dout : aux_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-port 1K x 16 data RAM between the CPU load/store port and an auxiliary port (debug loader / display scanner). It sits between the CPU memory interface (`write_en`, `addr`, `data_in`, `data_out`) and the RAM instance inside the board wrapper. It applies round-robin arbitration, supports a lock for atomic read-modify-write sequences, and routes 1-cycle-latency read data back to the requester that issued the read.

## Interface
- `ADDR_W`, 10, RAM address width
- `DATA_W`, 16, RAM data width
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`  in  1  CPU requests one access this cycle
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_lock`  in  1  hold ownership after this access
- `cpu_addr`  in  ADDR_W  access address
- `cpu_wdata`  in  DATA_W  write data
- `cpu_gnt`  out  1  access accepted this cycle (combinational)
- `cpu_rvalid`  out  1  read data valid, one cycle after a granted read
- `cpu_rdata`  out  DATA_W  read data
- `aux_req`, `aux_we`, `aux_lock`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`, `aux_rdata`: same as the `cpu_*` set, for the auxiliary port
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  ADDR_W  RAM address
- `ram_din`  out  DATA_W  RAM write data
- `ram_dout`  in  DATA_W  RAM read data; synchronous, valid on the edge after the address is presented

## Operation
- FSM states:
  - ARB: normal round-robin arbitration.
  - LOCK_CPU: CPU owns the RAM exclusively.
  - LOCK_AUX: auxiliary port owns the RAM exclusively.
- ARB, arbitration rules:
  - If exactly one port requests, that port is granted.
  - If both request, the port that did not win the previous grant is granted.
  - `last_win` updates on every grant.
  - If neither port requests, no grant is issued and `ram_we` = 0.
- Lock entry: a granted access with its `*_lock` = 1 moves the FSM to LOCK_x on the next edge.
- LOCK_x behaviour:
  - Only the owner can be granted; the other port's `gnt` = 0 even while it requests.
  - A granted owner access with `lock` = 0 returns the FSM to ARB. This is the last locked access.
  - The owner deasserting `req` does not release the lock.
  - The other port is not starved forever. `LOCK_MAX` = 16 consecutive locked cycles forces a return to ARB, with `last_win` = owner, so the other port wins the next tie.
- RAM mux:
  - `ram_addr`, `ram_din` and `ram_we` come from the granted port, or `ram_we` = 0 when nothing is granted.
  - When nothing is granted, `ram_addr` holds the CPU address. This value is don't-care and is not checked.
- Read return:
  - A registered tag records {valid, port} for each granted read.
  - On the next cycle, `ram_dout` is presented on that port's `rdata` and its `rvalid` pulses for one cycle.
  - `rdata` of the non-addressed port holds its last value.
  - A write does not produce `rvalid`.
- Back-to-back: a port can be granted on consecutive cycles. The read tag is overwritten each cycle, so every read returns exactly one `rvalid`.

## Timing
- Grant is combinational from `req` and registered state: zero-cycle accept.
- Read latency: `rvalid` is asserted exactly 1 cycle after the granted read.
- Write takes effect at the edge ending the grant cycle.
- Reset values:
  - FSM = ARB; `last_win` = AUX, so the CPU wins the first tie.
  - Lock counter = 0; read tag invalid.
  - `cpu_rvalid` = `aux_rvalid` = 0; `cpu_rdata` = `aux_rdata` = 0.
  - While `reset` = 1, both `gnt` = 0 and `ram_we` = 0.
- Reset mid-lock or with a read in flight: the lock and tag are dropped, and no `rvalid` follows.
- A granted access with `req` and `lock` both high on the LOCK_MAX-th cycle is still granted. The FSM then returns to ARB regardless of `lock`.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `LOCK_MAX` constant.
  - `arb_state_t` enum {ARB, LOCK_CPU, LOCK_AUX}.
  - `port_t` enum {PORT_CPU, PORT_AUX}.
- One sub-module, `rr_arb2`, holds the 2-requester round-robin pick. It is purely combinational given `last_win`; `last_win` is stored in `mem_arbiter`.
- Everything else stays in `mem_arbiter`: FSM, lock counter, read-tag register and the rdata holding registers.

## Test plan
- Single port: CPU writes 0xBEEF to 0x005, then reads 0x005. Required: `cpu_gnt` = 1 both cycles, and `cpu_rvalid` = 1 with `cpu_rdata` = 0xBEEF on the cycle after the read. `aux_rvalid` stays 0.
- Contention: both ports request reads every cycle for 6 cycles, starting from reset. Required: grants go CPU, AUX, CPU, AUX, CPU, AUX. Each `rvalid` appears on the matching port one cycle later.
- Lock: AUX reads 0x3FF with `aux_lock` = 1, then writes 0x0001 with `lock` = 0, while the CPU requests every cycle. Required: `cpu_gnt` = 0 for both AUX cycles, and the CPU is granted on the following cycle.
- Lock timeout: CPU holds `lock` = 1 with `req` = 1 for 20 cycles while AUX requests. Required: the CPU is granted 16 cycles, then AUX is granted on cycle 17.
- Reset mid-read: the CPU read of 0x010 is granted, then `reset` = 1 on the next edge. Required: no `cpu_rvalid`, both `rdata` = 0 and FSM = ARB. The first post-reset tie goes to the CPU.
- Idle: no requests for 4 cycles. Required: `ram_we` = 0, both `gnt` = 0 and no `rvalid`.
